// File: rtl/mux_seq_pkg.sv
// Shared definitions for the 8:1 mux sequencer.
//   state_e    : sequencer FSM states (IDLE waits for a word, SHIFT walks sel)
//   FRAME_BITS : bits per serialized frame (one per mux input)
//   SEL_W      : width of the mux select bus
package mux_seq_pkg;

    localparam int FRAME_BITS = 8;
    localparam int SEL_W      = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/mux_8to1.sv
// Plain combinational 8:1 multiplexer fed by the sequencer.
//   in  : 8 data inputs (in_bus from the sequencer)
//   sel : 3-bit select (sel from the sequencer)
//   out : in[sel]
module mux_8to1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_8to1_sequencer.sv
// Upstream driver for an 8:1 mux. Takes an 8-bit word over a valid/ready
// handshake, holds it on in_bus, and walks sel through all eight positions,
// one position every DIV clocks, strobing bit_valid when the mux output is
// ready to be sampled downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : word to serialize
//   load       : data_in valid
//   abort      : synchronous frame abort (wins over load and a final strobe)
//   ready      : word can be accepted this cycle
//   in_bus     : registered word driven to the mux data inputs
//   sel        : registered mux select
//   bit_valid  : mux output valid this cycle
//   last       : bit_valid qualifier for the 8th bit of the frame
//   busy       : frame in progress
//   done       : one-cycle pulse after a frame completes normally
//
// Handshake: a word transfers on a rising edge where load && ready (and no
// abort). ready is a function of state only, so load may be held high; it
// must not be derived combinationally from ready.
module mux_8to1_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic             load,
    input  logic             abort,
    output logic             ready,
    output logic [7:0]       in_bus,
    output logic [SEL_W-1:0] sel,
    output logic             bit_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int                 DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SEL_W-1:0]   FIRST_SEL = MSB_FIRST ? SEL_W'(FRAME_BITS - 1) : '0;
    localparam logic [2:0]         LAST_CNT  = 3'(FRAME_BITS - 1);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [7:0]         in_bus_q, in_bus_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               done_q, done_d;

    logic strobe;
    logic last_bit;
    logic accept;

    assign strobe   = (state_q == SHIFT) && (div_q == DIV_LAST);
    assign last_bit = strobe && (cnt_q == LAST_CNT);
    assign ready    = (state_q == IDLE) || last_bit;
    assign accept   = load && ready && !abort;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        in_bus_d = in_bus_q;
        sel_d    = sel_q;
        done_d   = 1'b0;

        if (abort) begin
            // In IDLE this only rewrites values that are already there.
            state_d = IDLE;
            sel_d   = FIRST_SEL;
            div_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            // Covers both a start from IDLE and a zero-bubble reload on the
            // final strobe; in the latter case the finished frame still
            // reports done.
            state_d  = SHIFT;
            in_bus_d = data_in;
            sel_d    = FIRST_SEL;
            div_d    = '0;
            cnt_d    = '0;
            done_d   = last_bit;
        end else if (strobe) begin
            div_d = '0;
            cnt_d = cnt_q + 3'd1;
            // After the 8th step sel wraps onto the next frame's first index.
            sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
            if (last_bit) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == SHIFT) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            in_bus_q <= '0;
            sel_q    <= FIRST_SEL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            in_bus_q <= in_bus_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
        end
    end

    assign in_bus    = in_bus_q;
    assign sel       = sel_q;
    assign bit_valid = strobe;
    assign last      = last_bit;
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_mux_8to1_sequencer.sv
// Bench for mux_8to1_sequencer: three instances (DIV=1 LSB-first,
// DIV=3 MSB-first, DIV=2 LSB-first), each feeding a mux_8to1. A timing model
// derived from the frame schedule (bit i at k+DIV*(i+1), last at k+8*DIV,
// done one cycle later) predicts every output each cycle, and a word
// scoreboard rebuilds each frame from the mux output.
module tb_mux_8to1_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n_v;
    logic [2:0] load_v;
    logic [2:0] abort_v;
    logic [7:0] din [3];
    logic [2:0] rdy, bv, lst, bsy, dn, mout;
    logic [7:0] ib [3];
    logic [2:0] sl [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux_8to1_sequencer #(
            .DIV       (g == 0 ? 1 : (g == 1 ? 3 : 2)),
            .MSB_FIRST (g == 1 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_v[g]),
            .data_in   (din[g]),
            .load      (load_v[g]),
            .abort     (abort_v[g]),
            .ready     (rdy[g]),
            .in_bus    (ib[g]),
            .sel       (sl[g]),
            .bit_valid (bv[g]),
            .last      (lst[g]),
            .busy      (bsy[g]),
            .done      (dn[g])
        );
        mux_8to1 u_mux (
            .in  (ib[g]),
            .sel (sl[g]),
            .out (mout[g])
        );
    end

    // ---------------- reference model ----------------
    int         dv_of  [3] = '{1, 3, 2};
    bit         msb_of [3] = '{1'b0, 1'b1, 1'b0};
    int         cyc = 0;
    bit         act [3];
    int         k_of [3];
    logic [7:0] word [3];
    int         done_at [3] = '{-1, -1, -1};
    int         n_acc [3];
    int         obs_done [3];
    int         exp_done [3];
    logic [7:0] exp_q [3][$];
    logic [7:0] got [3];
    int         nb [3];

    function automatic int t_of(int g);
        return cyc - k_of[g];
    endfunction

    function automatic bit m_bv(int g);
        return act[g] && ((t_of(g) % dv_of[g]) == 0);
    endfunction

    function automatic bit m_last(int g);
        return m_bv(g) && (t_of(g) == 8 * dv_of[g]);
    endfunction

    function automatic bit m_ready(int g);
        return !act[g] || m_last(g);
    endfunction

    function automatic logic [2:0] m_sel(int g);
        int pos;
        pos = act[g] ? (t_of(g) - 1) / dv_of[g] : 0;
        return msb_of[g] ? 3'(7 - pos) : 3'(pos);
    endfunction

    function automatic logic m_bit(int g);
        int n;
        int p;
        logic [7:0] w;
        n = t_of(g) / dv_of[g] - 1;
        p = msb_of[g] ? 7 - n : n;
        w = word[g];
        return w[p];
    endfunction

    always @(posedge clk) begin
        bit was_last;
        bit can;
        for (int g = 0; g < 3; g++) begin
            if (!rst_n_v[g]) begin
                act[g] = 1'b0; word[g] = 8'h00; done_at[g] = -1;
                exp_q[g].delete(); nb[g] = 0;
            end else if (abort_v[g]) begin
                act[g] = 1'b0; done_at[g] = -1;
                exp_q[g].delete(); nb[g] = 0;
            end else begin
                was_last = m_last(g);
                can      = m_ready(g);
                if (was_last) done_at[g] = cyc + 1;
                if (load_v[g] && can) begin
                    word[g] = din[g];
                    k_of[g] = cyc;
                    act[g]  = 1'b1;
                    n_acc[g]++;
                    exp_q[g].push_back(din[g]);
                end else if (was_last) begin
                    act[g] = 1'b0;
                end
            end
        end
        cyc++;
    end

    task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h cycle=%0d", tag, g, obs, exp, cyc);
        end
    endtask

    // ---------------- per-cycle checks and scoreboard ----------------
    always @(posedge clk) begin
        logic [7:0] w;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("ready",     g, rdy[g], m_ready(g));
            chk("busy",      g, bsy[g], act[g]);
            chk("bit_valid", g, bv[g],  m_bv(g));
            chk("last",      g, lst[g], m_last(g));
            chk("done",      g, dn[g],  cyc == done_at[g]);
            chk("in_bus",    g, ib[g],  word[g]);
            chk("sel",       g, sl[g],  m_sel(g));
            if (m_bv(g)) chk("mux_out", g, mout[g], m_bit(g));
            if (dn[g]) obs_done[g]++;
            if (cyc == done_at[g]) exp_done[g]++;
            if (bv[g] && nb[g] < 8) begin
                got[g][msb_of[g] ? 7 - nb[g] : nb[g]] = mout[g];
                nb[g]++;
            end
            if (bv[g] && lst[g]) begin
                chk("frame_pending", g, exp_q[g].size(), 1);
                if (exp_q[g].size() > 0) begin
                    w = exp_q[g].pop_front();
                    chk("frame_word", g, got[g], w);
                end
                nb[g] = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(int g, logic [7:0] w);
        int n;
        n = 0;
        while (!m_ready(g) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", g, rdy[g], 1);
        load_v[g] = 1'b1;
        din[g]    = w;
        @(negedge clk);
        load_v[g] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_v = 3'b000;
        load_v  = 3'b000;
        abort_v = 3'b000;
        for (int g = 0; g < 3; g++) din[g] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n_v = 3'b111;
        @(negedge clk);

        // single frame, DIV=1 LSB first
        send(0, 8'hA5);
        repeat (10) @(negedge clk);

        // single frame, DIV=3 MSB first
        send(1, 8'h81);
        repeat (28) @(negedge clk);
        chk("done_cnt_div3", 1, obs_done[1], 1);

        // back-to-back frames, zero bubble
        send(0, 8'hFF);
        send(0, 8'h00);
        repeat (10) @(negedge clk);
        chk("done_cnt_b2b", 0, obs_done[0], 3);

        // abort during bit 3, then a clean frame
        send(0, 8'h3C);
        repeat (3) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("done_cnt_abort", 0, obs_done[0], 3);
        send(0, 8'hC3);
        repeat (10) @(negedge clk);

        // asynchronous reset during bit 5
        send(0, 8'h77);
        repeat (5) @(negedge clk);
        rst_n_v[0] = 1'b0;
        #1;
        chk("rst_ready",  0, rdy[0], 1);
        chk("rst_in_bus", 0, ib[0],  0);
        chk("rst_sel",    0, sl[0],  0);
        chk("rst_bv",     0, bv[0],  0);
        chk("rst_last",   0, lst[0], 0);
        chk("rst_busy",   0, bsy[0], 0);
        chk("rst_done",   0, dn[0],  0);
        repeat (2) @(negedge clk);
        rst_n_v[0] = 1'b1;
        #1;
        chk("rel_ready", 0, rdy[0], 1);
        send(0, 8'h5A);
        repeat (10) @(negedge clk);
        chk("done_cnt_reset", 0, obs_done[0], 5);

        // load held high while busy, DIV=2
        load_v[2] = 1'b1;
        repeat (60) begin
            din[2] = 8'($urandom);
            @(negedge clk);
        end
        load_v[2] = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_done_cnt", 2, obs_done[2], 4);
        chk("held_words",    2, obs_done[2], n_acc[2]);

        // randomized traffic on all instances
        repeat (400) begin
            for (int g = 0; g < 3; g++) begin
                load_v[g]  = 1'($urandom_range(0, 1));
                din[g]     = 8'($urandom);
                abort_v[g] = ($urandom_range(0, 31) == 0);
            end
            @(negedge clk);
        end
        load_v  = 3'b000;
        abort_v = 3'b000;
        repeat (40) @(negedge clk);
        for (int g = 0; g < 3; g++) chk("done_total", g, obs_done[g], exp_done[g]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8to1_sequencer.md
# mux_8to1_sequencer

- Upstream driver for the 8:1 multiplexer.
- Accepts an 8-bit parallel word over a valid/ready handshake and holds it on the mux data bus.
- Steps the 3-bit mux select through all eight positions, one position every DIV clocks.
- Emits a sample strobe and a last-bit flag so the stage downstream of the mux can capture the serialized bit stream.

## Interface
- DIV, default 1: clocks per select position; legal range 1..256.
- MSB_FIRST, default 0: 0 = select order 0→7; 1 = select order 7→0.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  word to serialize.
- load  input  1  data_in valid; accepted when load && ready.
- abort  input  1  synchronous frame abort.
- ready  output  1  sequencer can accept a word this cycle.
- in_bus  output  8  registered word presented to the mux `in` port.
- sel  output  3  registered select presented to the mux `sel` port.
- bit_valid  output  1  mux output is valid this cycle; downstream samples here.
- last  output  1  qualifies bit_valid for the 8th bit of the frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after a frame completes normally.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - ready=1, busy=0.
  - On load, capture data_in into in_bus.
  - Set sel to the first index (0, or 7 when MSB_FIRST=1), clear the divider and bit counter, and go to SHIFT.
- SHIFT:
  - busy=1.
  - The divider counts 0..DIV-1; bit_valid=1 when divider==DIV-1.
  - On each bit_valid, increment the bit counter, and step sel by +1 (or -1 when MSB_FIRST=1).
  - last = bit_valid && bit counter==7.
- Frame end:
  - On the last strobe, done is registered for the next cycle.
  - If load is also high in that cycle (ready=1 then), the new word is captured, sel reloads to the first index, and the state stays in SHIFT with zero bubble.
  - Otherwise the state goes to IDLE.
- ready = (state==IDLE) || last. It is combinational; load must not depend on ready within the same cycle through combinational logic.
- in_bus holds its value after a frame ends, until the next accepted load.
- sel wraps naturally after the last step (7→0 or 0→7). In IDLE, sel holds the first index of the next frame.
- abort:
  - Forces IDLE on the next edge. bit_valid, last and done stay 0 from that edge onward, and no done pulse is issued.
  - abort has priority over load and over a coincident last strobe.
  - abort in IDLE has no effect.
- Divider width: max(1, $clog2(DIV)). Bit counter width: 3 bits.

## Timing
- Reset (rst_n=0, asynchronous):
  - State IDLE; in_bus=0, sel=0 (sel=7 if MSB_FIRST=1).
  - bit_valid=0, last=0, busy=0, done=0, ready=1.
- Reset mid-frame discards the frame immediately with no done pulse.
- Load accepted at edge k: in_bus and sel are valid from cycle k+1.
- Bit i (i=0..7) is strobed in cycle k+DIV·(i+1).
- last is strobed in cycle k+8·DIV. done=1 in cycle k+8·DIV+1.
- Sustained throughput: one word per 8·DIV clocks with back-to-back loads.
- DIV=1: bit_valid is high continuously across back-to-back frames; last is high every 8th cycle.

## Structure
- Package mux_seq_pkg:
  - state enum {IDLE, SHIFT}.
  - Constants: FRAME_BITS=8, SEL_W=3.
- Single module; no sub-module.
- The bench instantiates mux_8to1 fed by in_bus/sel and checks its out on every bit_valid.

## Test plan
- DIV=1, MSB_FIRST=0, load 8'hA5 → sampled bits 1,0,1,0,0,1,0,1; last in cycle 8; done in cycle 9; ready low in cycles 1..7.
- DIV=3, MSB_FIRST=1, load 8'h81 → sel sequence 7..0, each held 3 clocks; bits 1,0,0,0,0,0,0,1; done at cycle 25.
- DIV=1, back-to-back loads 8'hFF then 8'h00 → 16 contiguous bit_valid cycles; two last pulses 8 apart; two done pulses; no bubble.
- abort asserted during bit 3 of 8'h3C → IDLE next edge; no further bit_valid; no done; next load 8'hC3 serializes correctly from bit 0.
- rst_n low for 2 cycles during bit 5 → all outputs at reset values immediately and asynchronously; ready=1 after release; new frame 8'h5A is correct.
- load held high while busy with DIV=2 → only words presented while ready=1 are accepted; the word count matches the done count.
